// File: rtl/aes_pkg.sv
// Shared AES helpers: key-length geometry, rcon stepping, expander state and
// the InvMixColumns column transform also used by the decrypt rounds.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GEN,
    ST_HOLD
  } ks_state_e;

  localparam logic [7:0] RCON_INIT = 8'h01;

  function automatic int nk_of(input int key_bits);
    return key_bits / 32;
  endfunction

  function automatic int nr_of(input int key_bits);
    return key_bits / 32 + 6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] mul11(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] mul13(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] mul14(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  // Byte 0 of the column sits in bits [31:24].
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {mul14(a0) ^ mul11(a1) ^ mul13(a2) ^ mul9(a3),
            mul9(a0)  ^ mul14(a1) ^ mul11(a2) ^ mul13(a3),
            mul13(a0) ^ mul9(a1)  ^ mul14(a2) ^ mul11(a3),
            mul11(a0) ^ mul13(a1) ^ mul9(a2)  ^ mul14(a3)};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in and one byte out.
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);

  // Entry 0 occupies the top byte; ~a_i turns the byte value into an LSB-first offset.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign s_o = SBOX_TBL[{~a_i, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_schedule.sv
// AES key expander: one schedule word per cycle, round keys 0..Nr on a valid/ready stream.
// Define AES_KEY_SCHED_EQINV_EN to add dec_mode and equivalent-inverse round key output.
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key,
`ifdef AES_KEY_SCHED_EQINV_EN
  input  logic                dec_mode,
`endif
  output logic                ready,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic [127:0]        rk,
  output logic [3:0]          rk_idx,
  output logic                rk_last
);

  localparam int         NK    = nk_of(KEY_BITS);
  localparam int         NR    = nr_of(KEY_BITS);
  localparam logic [5:0] NK_W  = 6'(NK);
  localparam logic [2:0] NK_M1 = 3'(NK - 1);
  localparam logic [3:0] NR_I  = 4'(NR);

  ks_state_e    state_q, state_d;
  logic [31:0]  win_q [NK];
  logic [31:0]  win_d [NK];
  logic [31:0]  stg_q [3];
  logic [31:0]  stg_d [3];
  logic [5:0]   i_q, i_d;
  logic [2:0]   m_q, m_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   idx_q, idx_d;

  logic [31:0]  prev_w, sub_in, sub_w, word;
  logic [127:0] grp, grp_out;
  logic         gen_en;

  // win_q[0] is w[i-Nk], win_q[NK-1] is w[i-1]; during the first Nk cycles the
  // window simply rotates the key words through so the steady-state taps line up.
  assign prev_w = win_q[NK-1];
  assign sub_in = (m_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .a_i (sub_in[8*b +: 8]),
      .s_o (sub_w[8*b +: 8])
    );
  end

  always_comb begin
    word = win_q[0] ^ prev_w;
    if (i_q < NK_W) begin
      word = win_q[0];
    end else if (m_q == 3'd0) begin
      word = win_q[0] ^ sub_w ^ {rcon_q, 24'h0};
    end else if (NK == 8 && m_q == 3'd4) begin
      word = win_q[0] ^ sub_w;
    end
  end

  assign grp     = {stg_q[0], stg_q[1], stg_q[2], word};
  assign rk_last = (idx_q == NR_I);
  // The word opening the next group is produced on the same edge the key is taken.
  assign gen_en  = (state_q == ST_GEN) ||
                   (state_q == ST_HOLD && rk_ready && !rk_last);

`ifdef AES_KEY_SCHED_EQINV_EN
  logic dec_q, dec_d;

  always_comb begin
    grp_out = grp;
    if (dec_q && idx_q != 4'd0 && idx_q != NR_I) begin
      grp_out = {inv_mix_col(grp[127:96]), inv_mix_col(grp[95:64]),
                 inv_mix_col(grp[63:32]),  inv_mix_col(grp[31:0])};
    end
  end

  always_comb begin
    dec_d = dec_q;
    if (state_q == ST_IDLE && start) dec_d = dec_mode;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) dec_q <= 1'b0;
    else       dec_q <= dec_d;
  end
`else
  assign grp_out = grp;
`endif

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    stg_d   = stg_q;
    i_d     = i_q;
    m_d     = m_q;
    rcon_d  = rcon_q;
    rk_d    = rk_q;
    idx_d   = idx_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          for (int j = 0; j < NK; j++) win_d[j] = key[KEY_BITS-1-32*j -: 32];
          i_d     = 6'd0;
          m_d     = 3'd0;
          rcon_d  = RCON_INIT;
          idx_d   = 4'd0;
          state_d = ST_GEN;
        end
      end
      ST_HOLD: begin
        if (rk_ready) begin
          if (rk_last) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_GEN;
          end
        end
      end
      default: ;
    endcase

    if (gen_en) begin
      for (int j = 0; j < NK - 1; j++) win_d[j] = win_q[j+1];
      win_d[NK-1] = word;
      stg_d[0]    = stg_q[1];
      stg_d[1]    = stg_q[2];
      stg_d[2]    = word;
      i_d         = i_q + 6'd1;
      m_d         = (m_q == NK_M1) ? 3'd0 : m_q + 3'd1;
      if (i_q >= NK_W && m_q == 3'd0) rcon_d = xtime(rcon_q);
      if (i_q[1:0] == 2'b11) begin
        rk_d    = grp_out;
        state_d = ST_HOLD;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      for (int j = 0; j < NK; j++) win_q[j] <= '0;
      for (int j = 0; j < 3; j++) stg_q[j] <= '0;
      i_q     <= '0;
      m_q     <= '0;
      rcon_q  <= '0;
      rk_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      stg_q   <= stg_d;
      i_q     <= i_d;
      m_q     <= m_d;
      rcon_q  <= rcon_d;
      rk_q    <= rk_d;
      idx_q   <= idx_d;
    end
  end

  assign ready    = (state_q == ST_IDLE);
  assign rk_valid = (state_q == ST_HOLD);
  assign rk       = rk_q;
  assign rk_idx   = idx_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Bench for aes_key_schedule: 128/192/256-bit instances against a FIPS-197 expansion model.
module tb_aes_key_schedule;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start_s [3];
  logic         rkr_s   [3];
  logic [255:0] keyl    [3];
  wire          ready_w [3];
  wire          valid_w [3];
  wire          last_w  [3];
  wire  [127:0] rk_w    [3];
  wire  [3:0]   idx_w   [3];
`ifdef AES_KEY_SCHED_EQINV_EN
  logic         dec_s   [3];
  bit           mdec    [3];
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int nk_t [3] = '{4, 6, 8};

  // Model/scoreboard state, owned by the compare process.
  bit           act [3];
  bit           held [3];
  int           e [3];
  int           due [3];
  int           ek [3];
  logic [255:0] mkey [3];
  logic [127:0] held_rk [3];
  logic [127:0] cap [3][15];
  int           cap_e [3][15];
  logic [7:0]   sbt [256];

  aes_key_schedule #(.KEY_BITS(128)) u128 (
    .clk(clk), .reset(rst), .start(start_s[0]), .key(keyl[0][255:128]),
`ifdef AES_KEY_SCHED_EQINV_EN
    .dec_mode(dec_s[0]),
`endif
    .ready(ready_w[0]), .rk_valid(valid_w[0]), .rk_ready(rkr_s[0]),
    .rk(rk_w[0]), .rk_idx(idx_w[0]), .rk_last(last_w[0]));

  aes_key_schedule #(.KEY_BITS(192)) u192 (
    .clk(clk), .reset(rst), .start(start_s[1]), .key(keyl[1][255:64]),
`ifdef AES_KEY_SCHED_EQINV_EN
    .dec_mode(dec_s[1]),
`endif
    .ready(ready_w[1]), .rk_valid(valid_w[1]), .rk_ready(rkr_s[1]),
    .rk(rk_w[1]), .rk_idx(idx_w[1]), .rk_last(last_w[1]));

  aes_key_schedule #(.KEY_BITS(256)) u256 (
    .clk(clk), .reset(rst), .start(start_s[2]), .key(keyl[2]),
`ifdef AES_KEY_SCHED_EQINV_EN
    .dec_mode(dec_s[2]),
`endif
    .ready(ready_w[2]), .rk_valid(valid_w[2]), .rk_ready(rkr_s[2]),
    .rk(rk_w[2]), .rk_idx(idx_w[2]), .rk_last(last_w[2]));

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int n = 0; n < 8; n++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rol1(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction

  // S-box from its definition: multiplicative inverse then the affine map.
  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rol1(inv) ^ rol1(rol1(inv)) ^ rol1(rol1(rol1(inv)))
          ^ rol1(rol1(rol1(rol1(inv)))) ^ 8'h63;
      sbt[x] = s;
    end
  end

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbt[x[31:24]], sbt[x[23:16]], sbt[x[15:8]], sbt[x[7:0]]};
  endfunction

  function automatic logic [127:0] model_rk(input int nk, input logic [255:0] k0, input int k);
    logic [31:0]  w [60];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [255:0] ks;
    rc = 8'h01;
    for (int i = 0; i < 4 * (k + 1); i++) begin
      if (i < nk) begin
        ks   = k0 << (32 * i);
        w[i] = ks[255:224];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = gm(rc, 8'h02);
        end else if (nk == 8 && i % nk == 4) begin
          t = subw(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    return {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endfunction

`ifdef AES_KEY_SCHED_EQINV_EN
  function automatic logic [31:0] imc_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m [4][4];
    logic [31:0] r;
    m = '{'{8'd14, 8'd11, 8'd13, 8'd9}, '{8'd9, 8'd14, 8'd11, 8'd13},
          '{8'd13, 8'd9, 8'd14, 8'd11}, '{8'd11, 8'd13, 8'd9, 8'd14}};
    a = '{c[31:24], c[23:16], c[15:8], c[7:0]};
    r = '0;
    for (int row = 0; row < 4; row++)
      r[31-8*row -: 8] = gm(m[row][0], a[0]) ^ gm(m[row][1], a[1])
                       ^ gm(m[row][2], a[2]) ^ gm(m[row][3], a[3]);
    return r;
  endfunction

  function automatic logic [127:0] imc128(input logic [127:0] x);
    return {imc_col(x[127:96]), imc_col(x[95:64]), imc_col(x[63:32]), imc_col(x[31:0])};
  endfunction
`endif

  function automatic logic [127:0] exp_rk(input int d, input int k);
    logic [127:0] r;
    r = model_rk(nk_t[d], mkey[d], k);
`ifdef AES_KEY_SCHED_EQINV_EN
    if (mdec[d] && k != 0 && k != nk_t[d] + 6) r = imc128(r);
`endif
    return r;
  endfunction

  task automatic chk(input string nm, input int d, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h, expected %h", nm, d, got, exp);
    end
  endtask

  bit           c_was, c_v;
  logic [127:0] c_er;

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        act[d]  = 1'b0;
        held[d] = 1'b0;
      end else begin
        c_was = act[d];
        if (act[d]) e[d]++;
        chk("ready", d, 128'(ready_w[d]), 128'(!act[d]));
        c_v = act[d] && (e[d] >= due[d]);
        chk("rk_valid", d, 128'(valid_w[d]), 128'(c_v));
        if (c_v) begin
          c_er = exp_rk(d, ek[d]);
          chk("rk", d, rk_w[d], c_er);
          chk("rk_idx", d, 128'(idx_w[d]), 128'(ek[d]));
          chk("rk_last", d, 128'(last_w[d]), 128'(ek[d] == nk_t[d] + 6));
          if (held[d]) chk("rk_stable", d, rk_w[d], held_rk[d]);
          if (e[d] == due[d]) begin
            cap[d][ek[d]]   = rk_w[d];
            cap_e[d][ek[d]] = e[d];
          end
          if (rkr_s[d]) begin
            held[d] = 1'b0;
            if (ek[d] == nk_t[d] + 6) act[d] = 1'b0;
            else begin
              ek[d]++;
              due[d] = e[d] + 4;
            end
          end else begin
            held[d]    = 1'b1;
            held_rk[d] = rk_w[d];
          end
        end
        if (!c_was && start_s[d]) begin
          act[d]  = 1'b1;
          e[d]    = -1;
          ek[d]   = 0;
          due[d]  = 4;
          held[d] = 1'b0;
          mkey[d] = keyl[d];
`ifdef AES_KEY_SCHED_EQINV_EN
          mdec[d] = dec_s[d];
`endif
          for (int k = 0; k < 15; k++) begin
            cap[d][k]   = '0;
            cap_e[d][k] = -1;
          end
        end
      end
    end
  end

  task automatic launch(input int d, input logic [255:0] k);
    @(posedge clk); #2;
    keyl[d]    = k;
    start_s[d] = 1'b1;
    @(posedge clk); #2;
    start_s[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input int budget);
    int n;
    n = 0;
    while (act[d] && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    chk("run_complete", d, 128'(act[d]), 128'(0));
  endtask

  task automatic wait_key(input int d, input int k);
    for (int n = 0; n < 200 && ek[d] != k; n++) begin
      @(posedge clk); #2;
    end
    chk("reach_idx", d, 128'(ek[d]), 128'(k));
  endtask

  task automatic wait_valid(input int d);
    for (int n = 0; n < 20 && !valid_w[d]; n++) begin
      @(posedge clk); #2;
    end
    chk("valid_seen", d, 128'(valid_w[d]), 128'(1));
  endtask

  task automatic chk_reset_outputs(input int d);
    chk("rst_ready", d, 128'(ready_w[d]), 128'(1));
    chk("rst_valid", d, 128'(valid_w[d]), 128'(0));
    chk("rst_rk", d, rk_w[d], 128'(0));
    chk("rst_idx", d, 128'(idx_w[d]), 128'(0));
    chk("rst_last", d, 128'(last_w[d]), 128'(0));
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      start_s[d] = 1'b0;
      rkr_s[d]   = 1'b1;
      keyl[d]    = '0;
`ifdef AES_KEY_SCHED_EQINV_EN
      dec_s[d]   = 1'b0;
`endif
    end
    #3;
    for (int d = 0; d < 3; d++) chk_reset_outputs(d);
    @(posedge clk); #2;
    rst = 1'b0;

    // Pin the model against published expansion results.
    chk("model128_1", 0, model_rk(4, K128, 1), 128'ha0fafe1788542cb123a339392a6c7605);
    chk("model128_10", 0, model_rk(4, K128, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("model192_12", 1, model_rk(6, K192, 12), 128'he98ba06f448c773c8ecc720401002202);
    chk("model256_1", 2, model_rk(8, K256, 1), 128'h1f352c073b6108d72d9810a30914dff4);
    chk("model256_14", 2, model_rk(8, K256, 14), 128'hfe4890d1e6188d0b046df344706c631e);

    launch(0, K128);
    wait_done(0, 300);
    chk("k128_rk0", 0, cap[0][0], K128[255:128]);
    chk("k128_rk1", 0, cap[0][1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("k128_rk1_edge", 0, 128'(cap_e[0][1]), 128'(8));
    chk("k128_rk10", 0, cap[0][10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("k128_rk10_edge", 0, 128'(cap_e[0][10]), 128'(44));

    launch(1, K192);
    wait_done(1, 300);
    chk("k192_rk12", 1, cap[1][12], 128'he98ba06f448c773c8ecc720401002202);
    chk("k192_rk12_edge", 1, 128'(cap_e[1][12]), 128'(52));

    launch(2, K256);
    wait_done(2, 300);
    chk("k256_rk0", 2, cap[2][0], K256[255:128]);
    chk("k256_rk1", 2, cap[2][1], 128'h1f352c073b6108d72d9810a30914dff4);
    chk("k256_rk14", 2, cap[2][14], 128'hfe4890d1e6188d0b046df344706c631e);
    chk("k256_rk14_edge", 2, 128'(cap_e[2][14]), 128'(60));

    // Backpressure: hold key 3 for seven cycles.
    launch(0, K128);
    wait_key(0, 3);
    rkr_s[0] = 1'b0;
    wait_valid(0);
    repeat (7) @(posedge clk);
    #2;
    rkr_s[0] = 1'b1;
    wait_done(0, 300);
    chk("bp_rk3", 0, cap[0][3], 128'h3d80477d4716fe3e1e237e446d7a883b);
    chk("bp_rk10", 0, cap[0][10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("bp_rk10_edge", 0, 128'(cap_e[0][10]), 128'(51));

    // Abort with round key 5 pending, then rerun with a stray start during generation.
    launch(0, K128);
    wait_key(0, 5);
    rkr_s[0] = 1'b0;
    wait_valid(0);
    chk("pending_idx", 0, 128'(idx_w[0]), 128'(5));
    rst = 1'b1;
    #1;
    chk_reset_outputs(0);
    @(posedge clk); #2;
    rst = 1'b0;
    rkr_s[0] = 1'b1;
    launch(0, K128);
    @(posedge clk); #2;
    keyl[0]    = K256;
    start_s[0] = 1'b1;
    @(posedge clk); #2;
    start_s[0] = 1'b0;
    wait_done(0, 300);
    chk("rerun_rk0", 0, cap[0][0], K128[255:128]);
    chk("rerun_rk10", 0, cap[0][10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("rerun_rk10_edge", 0, 128'(cap_e[0][10]), 128'(44));

`ifdef AES_KEY_SCHED_EQINV_EN
    dec_s[0] = 1'b1;
    launch(0, K128);
    dec_s[0] = 1'b0;
    wait_done(0, 300);
    chk("dec_rk0", 0, cap[0][0], K128[255:128]);
    chk("dec_rk1", 0, cap[0][1], imc128(128'ha0fafe1788542cb123a339392a6c7605));
    chk("dec_rk10", 0, cap[0][10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

- Parametrised AES key expander for KEY_BITS = 128, 192 or 256 (Nk = 4/6/8, Nr = 10/12/14).
- Accepts a cipher key with a start/ready handshake and generates the expanded schedule one 32-bit word per cycle.
- Emits each 128-bit round key 0..Nr in order on a valid/ready stream with backpressure.
- Feeds the round pipeline and replaces the fixed 128-bit expander.

## Interface
- KEY_BITS, 128, cipher key length; only 128, 192 and 256 are legal.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  key load request; accepted when start && ready.
- key  in  KEY_BITS  cipher key, FIPS-197 byte order; word 0 = key[KEY_BITS-1 -: 32].
- ready  out  1  idle, can accept start.
- rk_valid  out  1  rk, rk_idx and rk_last are valid.
- rk_ready  in  1  consumer accepts the round key.
- rk  out  128  round key; w[4k] is in rk[127:96].
- rk_idx  out  4  round index k, 0..Nr.
- rk_last  out  1  high when rk_idx == Nr.

## Operation
- States: IDLE, GEN, HOLD.
- IDLE:
  - ready = 1.
  - On start && ready: latch key into an Nk-word window, clear word counter i to 0, set rcon = 8'h01, go to GEN.
- GEN: each cycle produces word w[i] and appends it to the 4-word staging buffer.
  - i < Nk: w[i] = key word i.
  - i mod Nk == 0: w[i] = w[i-Nk] ^ SubWord(RotWord(w[i-1])) ^ {rcon, 24'h0}. Then rcon <= xtime(rcon): shift left 1, XOR 8'h1b if bit7 was set.
  - Nk == 8 and i mod 8 == 4: w[i] = w[i-8] ^ SubWord(w[i-1]).
  - Otherwise: w[i] = w[i-Nk] ^ w[i-1].
  - The window shifts by one word every generating cycle. i counts to 4(Nr+1)-1 (43/51/59).
- When a group of 4 words completes: load rk, set rk_valid, go to HOLD.
- HOLD:
  - rk_valid && !rk_ready: generation stalls. rk, rk_idx, rk_last, window, i and rcon are frozen.
  - rk_valid && rk_ready, not last: rk_valid deasserts next cycle, rk_idx increments, return to GEN.
  - rk_valid && rk_ready && rk_last: go to IDLE, ready = 1 next cycle.
- A start while not ready is ignored, and the key is not sampled.
- Reset mid-operation aborts immediately. There is no partial output and no replay.

## Timing
- Reset values: ready = 1, rk_valid = 0, rk = 0, rk_idx = 0, rk_last = 0. rcon, window and counter are cleared.
- Start is accepted at edge E0. Words are written at E1, E2, and so on, one per edge while not stalled.
- With rk_ready held high:
  - rk_valid for round key k rises after edge E(4k+4) and is high for exactly one cycle.
  - The next word is written in the cycle the key is accepted.
  - Last key after E44, E52 or E60 for 128, 192 or 256.
  - ready rises one cycle after the last acceptance.
- Throughput: one round key per 4 cycles; peak is limited by the single-word datapath.
- A stall of S cycles delays all later keys by exactly S cycles. Output values are unaffected.
- For KEY_BITS = 256, round keys 0 and 1 equal the raw key halves. For 192, round key 1 mixes key words 4-5 with generated words 6-7.

## Configuration
- AES_KEY_SCHED_EQINV_EN defined:
  - Adds input port dec_mode (1 bit), sampled at start acceptance.
  - When dec_mode = 1, round keys 1..Nr-1 are output through InvMixColumns applied per 32-bit column. Keys 0 and Nr are unchanged. This supports the equivalent inverse cipher.
  - The transform is registered into rk, so latency is unchanged.
- AES_KEY_SCHED_EQINV_EN undefined: no dec_mode port, keys are always raw, and no InvMixColumns logic is present.

## Structure
- Shared package aes_pkg holds:
  - nr_of(KEY_BITS) and nk_of(KEY_BITS) functions.
  - RCON_INIT = 8'h01 and the xtime function.
  - The state enum.
  - The InvMixColumns column function, shared with the decrypt rounds.
- One sub-module: aes_sbox (8-bit combinational S-box), instantiated 4 times to form SubWord.

## Test plan
- KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
  - rk_idx 0 = key.
  - rk_idx 1 = a0fafe1788542cb123a339392a6c7605 after E8.
  - rk_idx 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last=1 after E44.
- KEY_BITS=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> 13 keys; rk_idx 12 = e98ba06f448c773c8ecc720401002202 after E52.
- KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - rk_idx 1 = 1f352c073b6108d72d9810a30914dff4.
  - rk_idx 14 = fe4890d1e6188d0b046df344706c631e after E60.
- Backpressure: 128-bit vector with rk_ready low for 7 cycles on rk_idx 3 -> rk stable throughout, all keys match, last key after E51.
- Reset asserted while rk_idx = 5 is pending -> all outputs at reset values immediately. A new start then reproduces the full sequence from rk_idx 0. A start pulse during GEN is ignored.
- With AES_KEY_SCHED_EQINV_EN and dec_mode=1 -> rk_idx 0 and 10 are unchanged, and rk_idx 1 equals InvMixColumns(a0fafe1788542cb123a339392a6c7605).
